sumcheck_round_check: RTL and testbench
=======================================

SUMCHECK_ROUND_CHECK -- requirements
Module: sumcheck_round_check

Interface
REQ-001 Parameter: none; field width `F_NBITS`, modulus `F_PRIME` come from the shared field constants.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset; synchronous, active-high.
REQ-004 en  input  1  start request; a round starts on the 0->1 edge only.
REQ-005 claim_in  input  F_NBITS  prior-round claim H.
REQ-006 r  input  F_NBITS  verifier challenge for this round.
REQ-007 tree_en  output  1  enable to upstream adder tree.
REQ-008 v_sel  output  2  evaluation point requested upstream: 0, 1 or 2.
REQ-009 v_in  input  F_NBITS  upstream sum V(v_sel).
REQ-010 v_valid  input  1  upstream one-cycle ready pulse qualifying v_in.
REQ-011 ready  output  1  level; high when idle or done.
REQ-012 ready_pulse  output  1  one-cycle pulse on ready 0->1.
REQ-013 ok  output  1  V(0)+V(1) == H, valid while ready.
REQ-014 claim_out  output  F_NBITS  V(r), next-round claim, valid while ready.

Function
REQ-015 On the start edge, the block shall latch claim_in and r, clear ok, and drop ready the next cycle.
REQ-016 States: IDLE, REQ, WAIT, GAP, MUL1..MUL4, DONE; IDLE and DONE accept a start.
REQ-017 REQ: tree_en=1, v_sel=idx (idx starts at 0); go to WAIT.
REQ-018 WAIT: tree_en=1, hold v_sel.
REQ-019 WAIT exit on v_valid: store v_in to V[idx].
REQ-020 WAIT exit when idx<2: increment idx and go to GAP.
REQ-021 WAIT exit when idx==2: go to MUL1.
REQ-022 GAP: tree_en=0 for exactly one cycle so upstream sees a fresh rising edge; then go to REQ.
REQ-023 Arithmetic: d1=V1-V0 and d2=V2-2*V1+V0, all mod F_PRIME.
REQ-024 Subtraction shall add F_PRIME when the minuend is smaller; addition shall subtract F_PRIME when the sum is >=F_PRIME.
REQ-025 Multiply schedule on one shared multiplier:
  - MUL1: h = d2*INV2, where INV2=(F_PRIME+1)/2.
  - MUL2: q = r*(r-1).
  - MUL3: m = q*h.
  - MUL4: s = r*d1.
REQ-026 Each MULn shall pulse the multiplier en once and advance on its ready_pulse.
REQ-027 On the MUL4 result, claim_out shall be V0+s+m mod p and ok = ((V0+V1) mod p == H); state goes to DONE.
REQ-028 DONE: ready=1 and ready_pulse=1 on the entry cycle; outputs hold until the next start.
REQ-029 A start edge outside IDLE/DONE shall be ignored.
REQ-030 v_valid outside WAIT shall be ignored.
REQ-031 All inputs are reduced (<F_PRIME); claim_out shall always be reduced.
REQ-032 ok shall be computed even when false, and claim_out is still produced.

Reset
REQ-033 rst shall force IDLE from any state, including mid-collection or mid-multiply.
REQ-034 Reset values:
  - tree_en=0, v_sel=0, ok=0, claim_out=0.
  - ready=1, ready_pulse=0.
  - En-edge detector history=1, so en held high through reset does not start a round.
REQ-035 A multiplier result arriving after reset shall be discarded.

Structure
REQ-036 F_NBITS, F_PRIME, INV2 and the state enum shall live in the shared field arithmetic package.
REQ-037 One sub-module shall be used: field_multiplier (en/a/b -> ready_pulse/c), instantiated once.
REQ-038 Modular add/sub shall be inline combinational logic, not separate modules.

Verification
REQ-039 V=3,5,9; H=8; r=4 -> three tree_en bursts with v_sel 0,1,2; ok=1; claim_out=23; one ready_pulse.
REQ-040 V=3,5,9; H=8; r=0 -> claim_out=3.
REQ-041 V=3,5,9; H=8; r=1 -> claim_out=5.
REQ-042 V=3,5,9; H=9; r=4 -> ok=0, claim_out=23.
REQ-043 V0=F_PRIME-1, V1=2, V2=5, H=1, r=0 -> ok=1 (wrap); claim_out=F_PRIME-1.
REQ-044 rst asserted in WAIT with idx=1, then stray v_valid -> block is IDLE, ready=1, tree_en=0, no V update.
REQ-045 Second en edge during MUL2 -> ignored; a single ready_pulse follows at completion.

Source files
------------

// File: rtl/sumcheck_round_check_pkg.sv
// Shared field constants, FSM state encoding and modular add/sub helpers
// for the sumcheck round checker.
package sumcheck_round_check_pkg;

    localparam int              F_NBITS = 16;
    localparam logic [F_NBITS-1:0] F_PRIME = 16'd65521;
    localparam logic [F_NBITS-1:0] INV2    = 16'd32761;  // (F_PRIME+1)/2

    typedef enum logic [3:0] {
        S_IDLE, S_REQ, S_WAIT, S_GAP, S_MUL1, S_MUL2, S_MUL3, S_MUL4, S_DONE
    } state_t;

    function automatic logic [F_NBITS-1:0] mod_add(input logic [F_NBITS-1:0] a,
                                                   input logic [F_NBITS-1:0] b);
        logic [F_NBITS:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= {1'b0, F_PRIME})
            s = s - {1'b0, F_PRIME};
        return s[F_NBITS-1:0];
    endfunction

    // a - b wraps mod 2^F_NBITS, but the true result a-b+p fits, so the wrap cancels
    function automatic logic [F_NBITS-1:0] mod_sub(input logic [F_NBITS-1:0] a,
                                                   input logic [F_NBITS-1:0] b);
        if (a < b)
            return a + F_PRIME - b;
        return a - b;
    endfunction

endpackage

// File: rtl/sumcheck_round_check_mul.sv
// Bit-serial modular multiplier (MSB-first double-and-add), F_NBITS cycles
// per product; result held on c after the ready_pulse.
module field_multiplier
    import sumcheck_round_check_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [F_NBITS-1:0] a,
    input  logic [F_NBITS-1:0] b,
    output logic               ready_pulse,
    output logic [F_NBITS-1:0] c
);
    localparam int CW = $clog2(F_NBITS + 1);

    logic               busy;
    logic [CW-1:0]      cnt;
    logic [F_NBITS-1:0] a_q, b_q, acc, dbl, nxt;

    assign dbl = mod_add(acc, acc);
    assign nxt = b_q[F_NBITS-1] ? mod_add(dbl, a_q) : dbl;
    assign c   = acc;

    always_ff @(posedge clk) begin
        if (rst) begin
            busy        <= 1'b0;
            cnt         <= '0;
            a_q         <= '0;
            b_q         <= '0;
            acc         <= '0;
            ready_pulse <= 1'b0;
        end else begin
            ready_pulse <= 1'b0;
            if (!busy && en) begin
                busy <= 1'b1;
                cnt  <= CW'(F_NBITS);
                a_q  <= a;
                b_q  <= b;
                acc  <= '0;
            end else if (busy) begin
                acc <= nxt;
                b_q <= b_q << 1;
                cnt <= cnt - 1'b1;
                if (cnt == CW'(1)) begin
                    busy        <= 1'b0;
                    ready_pulse <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/sumcheck_round_check.sv
// One sumcheck verifier round: gathers V(0),V(1),V(2) from the adder tree,
// checks V0+V1==H and interpolates V(r) through one shared multiplier.
module sumcheck_round_check
    import sumcheck_round_check_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [F_NBITS-1:0] claim_in,
    input  logic [F_NBITS-1:0] r,
    output logic               tree_en,
    output logic [1:0]         v_sel,
    input  logic [F_NBITS-1:0] v_in,
    input  logic               v_valid,
    output logic               ready,
    output logic               ready_pulse,
    output logic               ok,
    output logic [F_NBITS-1:0] claim_out
);
    state_t             state, next;
    logic               en_q, start, go, issued, is_mul;
    logic [1:0]         idx;
    logic [F_NBITS-1:0] v0, v1, v2, h_claim, r_q, hv, q, m;
    logic [F_NBITS-1:0] d1, d2;
    logic               mul_en, mul_rdy;
    logic [F_NBITS-1:0] mul_a, mul_b, mul_c;

    assign start   = en & ~en_q;
    assign is_mul  = state inside {S_MUL1, S_MUL2, S_MUL3, S_MUL4};
    assign tree_en = (state == S_REQ) || (state == S_WAIT);
    assign v_sel   = tree_en ? idx : 2'd0;
    assign ready   = (state == S_IDLE) || (state == S_DONE);
    assign d1      = mod_sub(v1, v0);
    assign d2      = mod_add(mod_sub(v2, mod_add(v1, v1)), v0);

    field_multiplier u_mul (
        .clk        (clk),
        .rst        (rst),
        .en         (mul_en),
        .a          (mul_a),
        .b          (mul_b),
        .ready_pulse(mul_rdy),
        .c          (mul_c)
    );

    always_comb begin
        next   = state;
        go     = 1'b0;
        mul_a  = '0;
        mul_b  = '0;
        mul_en = is_mul && !issued;
        case (state)
            S_IDLE, S_DONE: if (start) begin go = 1'b1; next = S_REQ; end
            S_REQ:  next = S_WAIT;
            S_WAIT: if (v_valid) next = (idx == 2'd2) ? S_MUL1 : S_GAP;
            S_GAP:  next = S_REQ;
            S_MUL1: begin mul_a = d2;  mul_b = INV2;                if (mul_rdy) next = S_MUL2; end
            S_MUL2: begin mul_a = r_q; mul_b = mod_sub(r_q, F_NBITS'(1)); if (mul_rdy) next = S_MUL3; end
            S_MUL3: begin mul_a = q;   mul_b = hv;                  if (mul_rdy) next = S_MUL4; end
            S_MUL4: begin mul_a = r_q; mul_b = d1;                  if (mul_rdy) next = S_DONE; end
            default: next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            en_q        <= 1'b1;  // en held high through reset must not start a round
            idx         <= '0;
            issued      <= 1'b0;
            {v0, v1, v2} <= '0;
            {h_claim, r_q, hv, q, m} <= '0;
            ok          <= 1'b0;
            claim_out   <= '0;
            ready_pulse <= 1'b0;
        end else begin
            state       <= next;
            en_q        <= en;
            ready_pulse <= (next == S_DONE) && (state != S_DONE);
            if (go) begin
                h_claim <= claim_in;
                r_q     <= r;
                ok      <= 1'b0;
                idx     <= '0;
            end
            if (state == S_WAIT && v_valid) begin
                case (idx)
                    2'd0:    v0 <= v_in;
                    2'd1:    v1 <= v_in;
                    default: v2 <= v_in;
                endcase
                if (idx != 2'd2) idx <= idx + 2'd1;
            end
            if (mul_en)
                issued <= 1'b1;
            else if (is_mul && mul_rdy)
                issued <= 1'b0;
            if (mul_rdy) begin
                case (state)
                    S_MUL1: hv <= mul_c;
                    S_MUL2: q  <= mul_c;
                    S_MUL3: m  <= mul_c;
                    S_MUL4: begin
                        claim_out <= mod_add(mod_add(v0, mul_c), m);
                        ok        <= (mod_add(v0, v1) == h_claim);
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sumcheck_round_check.sv
// Directed bench: a small adder-tree responder serves V(v_sel) after each
// tree_en rising edge; expected claims are hand-computed.
module tb_sumcheck_round_check;
    import sumcheck_round_check_pkg::*;

    logic               clk = 1'b0;
    logic               rst, en;
    logic [F_NBITS-1:0] claim_in, r, v_in;
    logic               v_valid;
    logic               tree_en, ready, ready_pulse, ok;
    logic [1:0]         v_sel;
    logic [F_NBITS-1:0] claim_out;

    always #5 clk = ~clk;

    sumcheck_round_check dut (
        .clk(clk), .rst(rst), .en(en), .claim_in(claim_in), .r(r),
        .tree_en(tree_en), .v_sel(v_sel), .v_in(v_in), .v_valid(v_valid),
        .ready(ready), .ready_pulse(ready_pulse), .ok(ok), .claim_out(claim_out)
    );

    int n_chk = 0, n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // upstream adder-tree model
    logic [F_NBITS-1:0] vals [3];
    logic resp_en = 1'b0, stray = 1'b0, tree_q = 1'b0;
    int   bursts = 0, pulses = 0, dly = 0;
    int   sel_log [3];

    always @(negedge clk) begin
        v_valid = stray;
        if (ready_pulse) pulses++;
        if (!resp_en) dly = 0;
        else begin
            if (tree_en && !tree_q) begin
                if (bursts < 3) sel_log[bursts] = int'(v_sel);
                bursts++;
                dly = 3;
            end
            if (dly > 0) begin
                dly--;
                if (dly == 0) begin v_valid = 1'b1; v_in = vals[v_sel]; end
            end
        end
        tree_q = tree_en;
    end

    task automatic run_round(input string tag, input logic [F_NBITS-1:0] a0, a1, a2, h, rr,
                             input logic exp_ok, input logic [F_NBITS-1:0] exp_claim,
                             input bit poke);
        int cyc;
        vals[0] = a0; vals[1] = a1; vals[2] = a2;
        bursts = 0; pulses = 0;
        @(negedge clk);
        claim_in = h; r = rr; en = 1'b1;
        @(negedge clk);
        en = 1'b0;
        chk({tag, "_ready_drop"}, ready, 0);
        chk({tag, "_ok_clr"}, ok, 0);
        cyc = 0;
        while (!ready && cyc < 500) begin
            @(negedge clk);
            cyc++;
            if (poke && cyc == 40) en = 1'b1;
            if (poke && cyc == 41) en = 1'b0;
        end
        chk({tag, "_done_in_time"}, cyc < 500, 1);
        repeat (5) @(negedge clk);
        chk({tag, "_ok"}, ok, exp_ok);
        chk({tag, "_claim"}, claim_out, exp_claim);
        chk({tag, "_bursts"}, bursts, 3);
        chk({tag, "_pulses"}, pulses, 1);
        chk({tag, "_idle_tree"}, tree_en, 0);
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; claim_in = '0; r = '0; v_in = '0;
        repeat (3) @(negedge clk);
        chk("rst_ready", ready, 1);
        chk("rst_pulse", ready_pulse, 0);
        chk("rst_tree", tree_en, 0);
        chk("rst_vsel", v_sel, 0);
        chk("rst_ok", ok, 0);
        chk("rst_claim", claim_out, 0);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        chk("en_held_no_start", tree_en, 0);
        chk("en_held_ready", ready, 1);
        en = 1'b0;
        resp_en = 1'b1;

        run_round("r4", 3, 5, 9, 8, 4, 1'b1, 23, 1'b0);
        chk("sel0", sel_log[0], 0);
        chk("sel1", sel_log[1], 1);
        chk("sel2", sel_log[2], 2);
        run_round("r0", 3, 5, 9, 8, 0, 1'b1, 3, 1'b0);
        run_round("r1", 3, 5, 9, 8, 1, 1'b1, 5, 1'b0);
        run_round("badH", 3, 5, 9, 9, 4, 1'b0, 23, 1'b0);
        run_round("wrap", F_PRIME - 1, 2, 5, 1, 0, 1'b1, F_PRIME - 1, 1'b0);
        run_round("poke", 3, 5, 9, 8, 4, 1'b1, 23, 1'b1);
        repeat (30) @(negedge clk);
        chk("poke_no_restart", pulses, 1);

        // reset while waiting on V(1), then a stray v_valid
        vals[0] = 3; vals[1] = 5; vals[2] = 9;
        bursts = 0; pulses = 0;
        claim_in = 8; r = 4; en = 1'b1;
        @(negedge clk);
        en = 1'b0;
        for (int i = 0; i < 100 && bursts < 2; i++) @(negedge clk);
        chk("mid_second_burst", bursts, 2);
        @(negedge clk);
        resp_en = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        stray = 1'b1;
        @(negedge clk);
        stray = 1'b0;
        repeat (40) @(negedge clk);
        chk("mid_rst_ready", ready, 1);
        chk("mid_rst_tree", tree_en, 0);
        chk("mid_rst_pulses", pulses, 0);
        chk("mid_rst_claim", claim_out, 0);
        chk("mid_rst_ok", ok, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
